// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared serial bus: one-hot grant, ack timeout and tenure limit.
// Watches the active-low bus_util line to track transfer start, end and stalls.
module bus_arbiter_rr #(
    parameter int unsigned NUM_MASTERS = 12,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned MAX_HOLD    = 255,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_reqs,
    input  logic                   bus_util,
    output logic [NUM_MASTERS-1:0] m_grants,
    output logic [3:0]             mid_current,
    output logic [3:0]             state,
    output logic                   bus_active,
    output logic                   timeout
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StGrant   = 4'd1,
        StBusy    = 4'd2,
        StRelease = 4'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grants_q, grants_d;
    logic [3:0]             mid_q, mid_d;
    logic [3:0]             rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   bus_active_q, bus_active_d;

    logic [NUM_MASTERS-1:0] req_rot;
    logic [4:0]             scan_idx;
    logic [3:0]             win_idx;
    logic                   win_found;
    logic                   win_req;

    // Rotate requests so bit 0 is the master at rr_ptr; first set bit is the winner.
    always_comb begin
        req_rot   = (m_reqs >> rr_ptr_q) | (m_reqs << (5'(NUM_MASTERS) - 5'(rr_ptr_q)));
        win_found = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                scan_idx  = 5'(rr_ptr_q) + 5'(i);
                if (scan_idx >= 5'(NUM_MASTERS)) begin
                    scan_idx = scan_idx - 5'(NUM_MASTERS);
                end
            end
        end
        win_idx = scan_idx[3:0];
    end

    // Grant is held constant during a tenure, so masking picks out the owner's request.
    assign win_req = |(m_reqs & grants_q);

    always_comb begin
        state_d   = state_q;
        grants_d  = grants_q;
        mid_d     = mid_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d  = StGrant;
                    grants_d = NUM_MASTERS'(1) << win_idx;
                    mid_d    = win_idx;
                    cnt_d    = '0;
                end
            end
            StGrant: begin
                if (!bus_util) begin
                    state_d = StBusy;
                    cnt_d   = '0;
                end else if (!win_req) begin
                    state_d  = StRelease;
                    grants_d = '0;
                end else if (cnt_q == CNT_WIDTH'(ACK_TIMEOUT - 1)) begin
                    state_d   = StRelease;
                    grants_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StBusy: begin
                if (bus_util || !win_req) begin
                    state_d  = StRelease;
                    grants_d = '0;
                end else if (cnt_q == CNT_WIDTH'(MAX_HOLD - 1)) begin
                    state_d   = StRelease;
                    grants_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StRelease: begin
                state_d  = StIdle;
                cnt_d    = '0;
                rr_ptr_d = (mid_q == 4'(NUM_MASTERS - 1)) ? 4'd0 : mid_q + 4'd1;
            end
            default: begin
                state_d  = StIdle;
                grants_d = '0;
            end
        endcase
        bus_active_d = (state_d == StGrant) || (state_d == StBusy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grants_q     <= '0;
            mid_q        <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            bus_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grants_q     <= grants_d;
            mid_q        <= mid_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            bus_active_q <= bus_active_d;
        end
    end

    assign m_grants    = grants_q;
    assign mid_current = mid_q;
    assign state       = state_q;
    assign bus_active  = bus_active_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: cycle-level reference model plus directed scenarios.
module tb_bus_arbiter_rr;

    localparam int NM   = 12;
    localparam int ACK  = 16;
    localparam int HOLD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] m_reqs;
    logic          bus_util;
    logic [NM-1:0] m_grants;
    logic [3:0]    mid_current;
    logic [3:0]    state;
    logic          bus_active;
    logic          timeout;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    bus_arbiter_rr #(
        .NUM_MASTERS(NM),
        .ACK_TIMEOUT(ACK),
        .MAX_HOLD   (HOLD),
        .CNT_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_reqs     (m_reqs),
        .bus_util   (bus_util),
        .m_grants   (m_grants),
        .mid_current(mid_current),
        .state      (state),
        .bus_active (bus_active),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 waiting for ack, 2 transfer, 3 release.
    int md_state, md_owner, md_ptr, md_cnt;
    bit md_to;

    function automatic int pick(input logic [NM-1:0] req, input int ptr);
        for (int k = 0; k < NM; k++) begin
            if (req[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_state <= 0;
            md_owner <= 0;
            md_ptr   <= 0;
            md_cnt   <= 0;
            md_to    <= 1'b0;
        end else begin
            md_to <= 1'b0;
            case (md_state)
                0: if (pick(m_reqs, md_ptr) >= 0) begin
                    md_owner <= pick(m_reqs, md_ptr);
                    md_state <= 1;
                    md_cnt   <= 0;
                end
                1: if (!bus_util) begin
                    md_state <= 2;
                    md_cnt   <= 0;
                end else if (!m_reqs[md_owner]) begin
                    md_state <= 3;
                end else if (md_cnt == ACK - 1) begin
                    md_state <= 3;
                    md_to    <= 1'b1;
                end else begin
                    md_cnt <= md_cnt + 1;
                end
                2: if (bus_util || !m_reqs[md_owner]) begin
                    md_state <= 3;
                end else if (md_cnt == HOLD - 1) begin
                    md_state <= 3;
                    md_to    <= 1'b1;
                end else begin
                    md_cnt <= md_cnt + 1;
                end
                3: begin
                    md_ptr   <= (md_owner + 1) % NM;
                    md_state <= 0;
                end
                default: md_state <= 0;
            endcase
        end
    end

    logic [NM-1:0] exp_grants;
    bit            exp_active;

    always @(negedge clk) begin
        if (check_en) begin
            exp_active = (md_state == 1) || (md_state == 2);
            exp_grants = exp_active ? (NM'(1) << md_owner) : '0;
            n_tests++;
            if (m_grants !== exp_grants || state !== 4'(md_state) ||
                mid_current !== 4'(md_owner) || bus_active !== exp_active ||
                timeout !== md_to) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got g=%h st=%0d mid=%0d act=%b to=%b want g=%h st=%0d mid=%0d act=%b to=%b",
                         $time, m_grants, state, mid_current, bus_active, timeout,
                         exp_grants, md_state, md_owner, exp_active, md_to);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Wait for a grant; gap counts the grant-free cycles seen on the way.
    task automatic wait_grant(output int gap);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_grants != 0) return;
            gap++;
        end
        check("grant_wait_expired", int'(m_grants != 0), 1);
    endtask

    task automatic serve(input int busy);
        bus_util = 1'b0;
        repeat (busy) @(negedge clk);
        bus_util = 1'b1;
    endtask

    int gap, cnt;
    int rr_order [4] = '{2, 4, 2, 4};

    initial begin
        rst      = 1'b1;
        m_reqs   = '0;
        bus_util = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grants", m_grants, 0);
        check("rst_state", state, 0);
        check("rst_mid", mid_current, 0);
        check("rst_timeout", timeout, 0);
        rst      = 1'b0;
        check_en = 1'b1;

        // Single transfer by master 2
        @(negedge clk);
        m_reqs = 12'h004;
        @(negedge clk);
        check("t1_grant", m_grants, 'h004);
        check("t1_state_grant", state, 1);
        check("t1_mid", mid_current, 2);
        repeat (2) @(negedge clk);
        bus_util = 1'b0;
        @(negedge clk);
        check("t1_state_busy", state, 2);
        repeat (6) @(negedge clk);
        bus_util = 1'b1;
        @(negedge clk);
        check("t1_state_release", state, 3);
        check("t1_release_grant", m_grants, 0);
        check("t1_release_timeout", timeout, 0);
        m_reqs = '0;
        @(negedge clk);
        check("t1_state_idle", state, 0);
        // rr_ptr is 3 now, so master 1 loses to nobody but master 2 loses to 1? no: scan 3..11,0,1
        m_reqs = 12'h006;
        @(negedge clk);
        check("t1_rrptr_winner", mid_current, 1);
        check("t1_rrptr_grant", m_grants, 'h002);
        m_reqs = '0;
        @(negedge clk);
        check("abandon_release", state, 3);
        check("abandon_no_timeout", timeout, 0);
        @(negedge clk);

        // Stray bus_util low while idle
        bus_util = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_state", state, 0);
        check("stray_grant", m_grants, 0);
        bus_util = 1'b1;

        // Round robin between masters 2 and 4
        do_reset();
        m_reqs = 12'h014;
        for (int k = 0; k < 4; k++) begin
            wait_grant(gap);
            check("rr_order", mid_current, rr_order[k]);
            check("rr_onehot", m_grants, 1 << rr_order[k]);
            if (k > 0) check("rr_gap", gap, 2);
            serve(3);
        end
        m_reqs = '0;
        repeat (3) @(negedge clk);

        // Wrap-around through master 11 back to 0
        do_reset();
        m_reqs = 12'h400;
        wait_grant(gap);
        check("wrap_m10", mid_current, 10);
        serve(2);
        m_reqs = 12'h801;
        wait_grant(gap);
        check("wrap_m11", mid_current, 11);
        check("wrap_gap", gap, 2);
        serve(2);
        m_reqs = 12'h001;
        wait_grant(gap);
        check("wrap_m0", mid_current, 0);
        serve(2);
        m_reqs = '0;
        repeat (3) @(negedge clk);
        m_reqs = 12'h801;
        wait_grant(gap);
        check("wrap_ptr1", mid_current, 11);
        serve(2);
        m_reqs = '0;
        repeat (3) @(negedge clk);

        // Ack timeout: master 2 never takes the bus, master 4 waits
        m_reqs = 12'h014;
        wait_grant(gap);
        check("ack_m2", mid_current, 2);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state != 4'd1) break;
            cnt++;
        end
        check("ack_grant_cycles", cnt, ACK);
        check("ack_release", state, 3);
        check("ack_timeout_pulse", timeout, 1);
        @(negedge clk);
        check("ack_timeout_clear", timeout, 0);
        check("ack_gap_grant", m_grants, 0);
        @(negedge clk);
        check("ack_next_m4", m_grants, 'h010);

        // Tenure limit: master 4 holds bus_util low forever
        bus_util = 1'b0;
        @(negedge clk);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state != 4'd2) break;
            cnt++;
        end
        check("hold_busy_cycles", cnt, HOLD);
        check("hold_release", state, 3);
        check("hold_timeout_pulse", timeout, 1);
        repeat (2) @(negedge clk);
        check("hold_next_m2", m_grants, 'h004);
        bus_util = 1'b1;
        m_reqs   = '0;
        repeat (3) @(negedge clk);

        // bus_util falls as the request drops: transfer start wins
        m_reqs = 12'h010;
        wait_grant(gap);
        check("same_m4", mid_current, 4);
        bus_util = 1'b0;
        m_reqs   = '0;
        @(negedge clk);
        check("same_busy_wins", state, 2);
        @(negedge clk);
        check("same_then_release", state, 3);
        bus_util = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a transfer
        m_reqs = 12'h010;
        wait_grant(gap);
        bus_util = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_pre_busy", state, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_grant", m_grants, 0);
        check("arst_state", state, 0);
        check("arst_mid", mid_current, 0);
        check("arst_active", bus_active, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        m_reqs   = '0;
        bus_util = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin bus arbiter/scheduler for the shared serial bus.
- Takes the one-bit request lines from up to 16 masters and issues a single one-hot grant.
- Monitors the open-drain bus-utilization line (low means a transfer is in progress) to detect transfer start, end and stalls.
- Enforces an acknowledge timeout and a maximum tenure so no master can lock the bus. Sits beside the slave-routing logic in the bus top module.

Parameters:
NUM_MASTERS, 12, number of request/grant pairs (2..16)
ACK_TIMEOUT, 16, cycles a granted master may take to pull bus_util low before the grant is revoked
MAX_HOLD, 255, cycles bus_util may stay low within one tenure before a forced release
CNT_WIDTH, 8, width of the internal wait/tenure counter; must hold max(ACK_TIMEOUT, MAX_HOLD)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
m_reqs  input  NUM_MASTERS  request per master, level, held high until the transfer is finished
bus_util  input  1  bus-utilization line, active low (0 = transfer in progress)
m_grants  output  NUM_MASTERS  one-hot grant, registered
mid_current  output  4  index of the master currently or last granted
state  output  4  FSM state: 0 IDLE, 1 GRANT, 2 BUSY, 3 RELEASE
bus_active  output  1  high in GRANT or BUSY
timeout  output  1  one-cycle pulse on a forced release

Behaviour:
- Reset (asynchronous, any state): m_grants=0, mid_current=0, state=IDLE, bus_active=0, timeout=0, rr_ptr=0, counter=0. All outputs are registered.
- Winner selection:
  - Scan cyclically from rr_ptr upward, wrapping at NUM_MASTERS-1 back to 0; the first set m_reqs bit wins.
  - Bits at index NUM_MASTERS and above are ignored.
- IDLE:
  - If any request is set at edge n, the winner's grant bit and mid_current are valid after edge n (one-cycle latency). Next state is GRANT with counter=0.
  - With no request, stay in IDLE with grants at 0.
- GRANT (waiting for the master to take the bus):
  - bus_util==0: go to BUSY, counter=0.
  - Else, winner's request low: go to RELEASE (master abandoned).
  - Else, counter==ACK_TIMEOUT-1: go to RELEASE and pulse timeout.
  - Otherwise increment counter.
  - If bus_util falls and the request drops in the same cycle, BUSY wins.
- BUSY:
  - bus_util==1 (transfer done) or winner's request low: go to RELEASE.
  - Else, counter==MAX_HOLD-1: go to RELEASE and pulse timeout.
  - Otherwise increment counter.
- RELEASE (one cycle):
  - m_grants=0.
  - rr_ptr = mid_current+1, wrapping to 0 when it equals NUM_MASTERS.
  - Next state is IDLE.
  - The minimum gap between two grants is 2 cycles with grants low, giving the line turnaround.
- The grant stays one-hot or zero at all times; the grant bit is held constant from GRANT through BUSY.
- mid_current retains its value through RELEASE and IDLE until the next arbitration.
- timeout is high only in the first cycle of RELEASE that follows a forced exit; it is 0 otherwise.
- Requests from other masters during GRANT or BUSY have no effect until the next IDLE.
- bus_util low while in IDLE (a stray master) is ignored; no grant is issued on that basis.
- Reset mid-transfer drops the grant immediately (asynchronous).

Test Plan:
- Reset: assert rst mid-BUSY with master 4 granted -> m_grants=0, state=0, mid_current=0 within the same cycle, no clock edge needed.
- Single transfer: m_reqs=0x004 at edge 0 -> m_grants=0x004 and state=1 after edge 0; bus_util=0 at edge 3 -> state=2; bus_util=1 at edge 10 -> state=3, then 0; rr_ptr=3.
- Round robin: from reset, m_reqs=0x014 held; masters 2 and 4 complete alternately -> grant order 2, 4, 2, 4 with each grant separated by 2 grant-free cycles.
- Wrap-around: rr_ptr=11 (after serving master 10), m_reqs=0x801|0x001 -> master 11 wins, then master 0, then rr_ptr returns to 1.
- Ack timeout (ACK_TIMEOUT=16): grant master 2, bus_util held high -> exactly 16 cycles in GRANT, then RELEASE with timeout=1 for one cycle; master 4 (pending) is granted 2 cycles later.
- Tenure limit (MAX_HOLD=8): master 4 holds bus_util low indefinitely -> forced RELEASE after 8 BUSY cycles with a timeout pulse; grant moves to the next requester.
